// File: rtl/imem_ld_pkg.sv
// Shared types and sizing for the instruction-memory debug loader.
package imem_ld_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = 2;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } ld_state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word packer; the completing byte is forwarded
// combinationally so the caller can register the full word on the same edge.
module imem_byte_packer
    import imem_ld_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              clear_i,
    output logic [WORD_W-1:0] word_c_o,
    output logic              word_full_c_o
);

    localparam int unsigned HOLD_W = WORD_W - BYTE_W;

    logic [BYTE_IDX_W-1:0] idx_q;
    logic [HOLD_W-1:0]     hold_q;

    assign word_c_o      = {data_i, hold_q};
    assign word_full_c_o = valid_i && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    // Earlier bytes shift down so byte k lands at bits [8k+7:8k]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            hold_q <= '0;
        end else if (clear_i) begin
            idx_q  <= '0;
            hold_q <= '0;
        end else if (valid_i) begin
            idx_q  <= idx_q + BYTE_IDX_W'(1);
            hold_q <= {data_i, hold_q[HOLD_W-1:BYTE_W]};
        end
    end

endmodule

// File: rtl/imem_loader_ctrl.sv
// Debug program loader: packs streamed bytes into words and writes them to
// consecutive instruction-memory addresses while stalling the core.
module imem_loader_ctrl
    import imem_ld_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   word_cnt_i,
    input  logic              abort_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_data_i,
    output logic              byte_ready_o,
    output logic              dbg_we_o,
    output logic [31:0]       dbg_addr_o,
    output logic [31:0]       dbg_instr_o,
    output logic              core_stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned SUM_W = ADDR_W + 2;

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic              stall_q, stall_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              pack_valid;
    logic              pack_clear;
    logic [WORD_W-1:0] pack_word;
    logic              pack_full;
    logic              range_over;

    assign range_over = (SUM_W'(base_addr_i) + SUM_W'(word_cnt_i)) > SUM_W'(DEPTH);

    // Abort wins over a byte arriving in the same cycle
    assign pack_valid = byte_valid_i && ready_q && !abort_i;
    assign pack_clear = (state_q != COLLECT);

    imem_byte_packer u_packer (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (pack_valid),
        .data_i        (byte_data_i),
        .clear_i       (pack_clear),
        .word_c_o      (pack_word),
        .word_full_c_o (pack_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            waddr_q <= '0;
            instr_q <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            waddr_q <= waddr_d;
            instr_q <= instr_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state; outputs are decoded from the next state so they line up with it
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        waddr_d = waddr_q;
        instr_d = instr_q;
        err_d   = err_q;
        we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (range_over) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = base_addr_i;
                        rem_d   = word_cnt_i;
                        state_d = (word_cnt_i == '0) ? DONE : COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (abort_i) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (pack_full) begin
                    state_d = WRITE;
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    instr_d = pack_word;
                end
            end
            WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - CNT_W'(1);
                if (abort_i) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = COLLECT;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (abort_i) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == COLLECT);
        stall_d = (state_d == COLLECT) || (state_d == WRITE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    assign byte_ready_o = ready_q;
    assign dbg_we_o     = we_q;
    assign dbg_addr_o   = 32'(waddr_q);
    assign dbg_instr_o  = instr_q;
    assign core_stall_o = stall_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed bench for imem_loader_ctrl; expected imem writes are queued as
// words are sent and checked when the write strobe appears.
module tb_imem_loader_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [4:0]  base_addr_i;
    logic [5:0]  word_cnt_i;
    logic        abort_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        dbg_we_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_instr_o;
    logic        core_stall_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;
    int  we_count = 0;
    int  done_count = 0;
    bit  stall_seen = 1'b0;

    imem_loader_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .word_cnt_i   (word_cnt_i),
        .abort_i      (abort_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .dbg_we_o     (dbg_we_o),
        .dbg_addr_o   (dbg_addr_o),
        .dbg_instr_o  (dbg_instr_o),
        .core_stall_o (core_stall_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard side: every strobe must match the oldest queued write
    always @(negedge clk) begin
        if (!rst) begin
            if (core_stall_o) stall_seen = 1'b1;
            if (done_o) done_count++;
            if (dbg_we_o) begin
                wr_t e;
                we_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 32'(dbg_we_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", dbg_addr_o, e.addr);
                    check("wr_data", dbg_instr_o, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] base, input logic [5:0] cnt);
        start_i     = 1'b1;
        base_addr_i = base;
        word_cnt_i  = cnt;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        guard = 0;
        while (!byte_ready_o && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("byte_ready_timeout", 32'(byte_ready_o), 32'd1);
        tick();
        byte_valid_i = 1'b0;
        byte_data_i  = $urandom_range(0, 255);
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] word, input bit gaps);
        wr_t e;
        e.addr = addr;
        e.data = word;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) send_byte(word[8*k +: 8], gaps);
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (!done_o && n < max_cycles) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done_o), 32'd1);
        tick();
    endtask

    initial begin
        int w0;
        int d0;

        rst          = 1'b1;
        start_i      = 1'b0;
        base_addr_i  = '0;
        word_cnt_i   = '0;
        abort_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = '0;
        #3;
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_we",    32'(dbg_we_o), 32'd0);
        check("rst_stall", 32'(core_stall_o), 32'd0);
        check("rst_ready", 32'(byte_ready_o), 32'd0);
        check("rst_err",   32'(err_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single word, exact strobe latency and stall window
        do_start(5'd0, 6'd1);
        check("t1_stall_on", 32'(core_stall_o), 32'd1);
        check("t1_ready_on", 32'(byte_ready_o), 32'd1);
        send_word(32'd0, 32'h0000_0013, 1'b0);
        check("t1_we_latency", 32'(dbg_we_o), 32'd1);
        check("t1_ready_in_write", 32'(byte_ready_o), 32'd0);
        tick();
        check("t1_done", 32'(done_o), 32'd1);
        check("t1_stall_off", 32'(core_stall_o), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done_o), 32'd0);
        check("t1_idle", 32'(busy_o), 32'd0);

        // Three words with random valid gaps
        w0 = we_count;
        do_start(5'd4, 6'd3);
        send_word(32'd4, 32'hDEAD_BEEF, 1'b1);
        send_word(32'd5, 32'h0123_4567, 1'b1);
        send_word(32'd6, 32'hA5C3_0F81, 1'b1);
        wait_done(100);
        check("t2_strobes", 32'(we_count - w0), 32'd3);

        // Out-of-range start, then last-word boundary start clears the error
        w0 = we_count;
        do_start(5'd30, 6'd3);
        check("t3_err", 32'(err_o), 32'd1);
        check("t3_busy", 32'(busy_o), 32'd0);
        repeat (3) tick();
        check("t3_no_writes", 32'(we_count - w0), 32'd0);
        do_start(5'd31, 6'd1);
        check("t3_err_cleared", 32'(err_o), 32'd0);
        send_word(32'd31, 32'h0BAD_F00D, 1'b0);
        wait_done(20);

        // Zero-length load
        w0 = we_count;
        stall_seen = 1'b0;
        do_start(5'd0, 6'd0);
        check("t4_done", 32'(done_o), 32'd1);
        check("t4_stall", 32'(core_stall_o), 32'd0);
        tick();
        check("t4_done_pulse", 32'(done_o), 32'd0);
        check("t4_no_writes", 32'(we_count - w0), 32'd0);
        check("t4_stall_never", 32'(stall_seen), 32'd0);

        // Abort mid-word: only the first word lands
        w0 = we_count;
        d0 = done_count;
        do_start(5'd8, 6'd3);
        send_word(32'd8, 32'h1122_3344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t5_busy", 32'(busy_o), 32'd0);
        check("t5_err", 32'(err_o), 32'd1);
        check("t5_ready", 32'(byte_ready_o), 32'd0);
        repeat (2) tick();
        check("t5_writes", 32'(we_count - w0), 32'd1);
        check("t5_no_done", 32'(done_count - d0), 32'd0);

        // Abort coinciding with the write cycle keeps that strobe
        w0 = we_count;
        d0 = done_count;
        do_start(5'd10, 6'd2);
        check("t5b_err_cleared", 32'(err_o), 32'd0);
        send_word(32'd10, 32'hCAFE_0001, 1'b0);
        check("t5b_in_write", 32'(dbg_we_o), 32'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t5b_err", 32'(err_o), 32'd1);
        check("t5b_busy", 32'(busy_o), 32'd0);
        repeat (2) tick();
        check("t5b_writes", 32'(we_count - w0), 32'd1);
        check("t5b_no_done", 32'(done_count - d0), 32'd0);

        // Asynchronous reset mid-collect, then a clean reload
        do_start(5'd0, 6'd2);
        send_byte(8'hEE, 1'b0);
        send_byte(8'hFF, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_busy",  32'(busy_o), 32'd0);
        check("t6_stall", 32'(core_stall_o), 32'd0);
        check("t6_ready", 32'(byte_ready_o), 32'd0);
        check("t6_err",   32'(err_o), 32'd0);
        check("t6_addr",  dbg_addr_o, 32'd0);
        check("t6_instr", dbg_instr_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_start(5'd2, 6'd1);
        send_word(32'd2, 32'hDDCC_BBAA, 1'b1);
        wait_done(20);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("total_strobes", 32'(we_count), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
